// File: rtl/sm83_alu_pkg.sv
// Shared types for the nibble-serial SM83 ALU: op codes, FSM states, nibble core modes
// and the byte-wide shift/rotate helper.
package sm83_alu_pkg;

   localparam int NIBBLE = 4;

   typedef enum logic [4:0] {
      OP_ADD  = 5'd0,
      OP_ADC  = 5'd1,
      OP_SUB  = 5'd2,
      OP_SBC  = 5'd3,
      OP_AND  = 5'd4,
      OP_XOR  = 5'd5,
      OP_OR   = 5'd6,
      OP_CP   = 5'd7,
      OP_RLC  = 5'd8,
      OP_RRC  = 5'd9,
      OP_RL   = 5'd10,
      OP_RR   = 5'd11,
      OP_SLA  = 5'd12,
      OP_SRA  = 5'd13,
      OP_SRL  = 5'd14,
      OP_SWAP = 5'd15,
      OP_DAA  = 5'd16
   } alu_op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LO   = 2'd1,
      ST_HI   = 2'd2
   } alu_state_t;

   typedef enum logic [2:0] {
      NIB_ADD = 3'd0,
      NIB_SUB = 3'd1,
      NIB_AND = 3'd2,
      NIB_XOR = 3'd3,
      NIB_OR  = 3'd4
   } nib_mode_t;

   // Returns {bit shifted out, shifted byte}; SWAP shifts nothing out.
   function automatic logic [8:0] shift_op(input alu_op_t op, input logic [7:0] v,
                                           input logic cin);
      logic [8:0] r;
      r = {1'b0, v};
      case (op)
         OP_RLC:  r = {v[7], v[6:0], v[7]};
         OP_RRC:  r = {v[0], v[0], v[7:1]};
         OP_RL:   r = {v[7], v[6:0], cin};
         OP_RR:   r = {v[0], cin, v[7:1]};
         OP_SLA:  r = {v[7], v[6:0], 1'b0};
         OP_SRA:  r = {v[0], v[7], v[7:1]};
         OP_SRL:  r = {v[0], 1'b0, v[7:1]};
         OP_SWAP: r = {1'b0, v[3:0], v[7:4]};
         default: r = {1'b0, v};
      endcase
      return r;
   endfunction

endpackage

// File: rtl/sm83_alu_nibble.sv
// Combinational 4-bit ALU pass: add/subtract with carry (borrow) in and out, plus logic ops.
module sm83_alu_nibble
   import sm83_alu_pkg::*;
(
   input  logic [NIBBLE-1:0] a_i,
   input  logic [NIBBLE-1:0] b_i,
   input  logic              cin,
   input  nib_mode_t         mode,
   output logic [NIBBLE-1:0] y,
   output logic              cout
);

   logic [NIBBLE:0] sum;

   // For subtraction the wrapped top bit of the 5-bit difference is the borrow.
   always_comb begin
      sum = '0;
      case (mode)
         NIB_ADD: sum = {1'b0, a_i} + {1'b0, b_i} + {{NIBBLE{1'b0}}, cin};
         NIB_SUB: sum = {1'b0, a_i} - {1'b0, b_i} - {{NIBBLE{1'b0}}, cin};
         NIB_AND: sum = {1'b0, a_i & b_i};
         NIB_XOR: sum = {1'b0, a_i ^ b_i};
         NIB_OR:  sum = {1'b0, a_i | b_i};
         default: sum = '0;
      endcase
   end

   assign y    = sum[NIBBLE-1:0];
   assign cout = sum[NIBBLE];

endmodule

// File: rtl/sm83_alu_nibble_seq.sv
// Nibble-serial SM83 ALU: IDLE -> LO -> HI, one shared 4-bit core, registered result/flags.
// Handshake: start is sampled only in IDLE; valid pulses one cycle after the HI pass.
// Optional DAA support is enabled by defining SM83_ALU_DAA_EN.
module sm83_alu_nibble_seq
   import sm83_alu_pkg::*;
#(
   parameter int WORD_SIZE = 8
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start,
   input  alu_op_t              op,
   input  logic [WORD_SIZE-1:0] a,
   input  logic [WORD_SIZE-1:0] b,
   input  logic                 carry_in,
   input  logic                 half_in,
   input  logic                 neg_in,
   output logic                 busy,
   output logic                 valid,
   output logic [WORD_SIZE-1:0] result,
   output logic                 zero_out,
   output logic                 half_out,
   output logic                 carry_out,
   output logic                 neg_out,
   output logic                 shift_out,
   output logic                 daa_carry_out,
   output alu_state_t           state_dbg
);

   alu_state_t           state_q, state_d;
   alu_op_t              op_q, op_d;
   logic [WORD_SIZE-1:0] a_q, a_d, b_q, b_d;
   logic                 c_q, c_d, h_q, h_d, n_q, n_d;
   logic [NIBBLE-1:0]    lo_q, lo_d;
   logic                 nc_q, nc_d;
   logic [WORD_SIZE-1:0] result_q, result_d;
   logic                 zero_q, zero_d, half_q, half_d, carry_q, carry_d;
   logic                 neg_q, neg_d, shift_q, shift_d, daac_q, daac_d, valid_q, valid_d;

   logic [NIBBLE-1:0]    nib_a, nib_b, nib_y;
   logic                 nib_cin, nib_cout;
   nib_mode_t            nib_mode;
   logic [8:0]           sh;
   logic                 is_shift;
   logic [WORD_SIZE-1:0] res_full;

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start) state_d = ST_LO;
         ST_LO:   state_d = ST_HI;
         ST_HI:   state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy      = (state_q == ST_LO) || (state_q == ST_HI);
      state_dbg = state_q;
   end

`ifdef SM83_ALU_DAA_EN
   // DAA correction is decided once in LO from the whole latched A and reused in HI.
   logic [WORD_SIZE-1:0] corr_q, corr_d;
   logic                 daa_c_q, daa_c_d;
   logic                 corr_lo, corr_hi;

   always_comb begin
      corr_lo = h_q | (~n_q & (a_q[NIBBLE-1:0] > 4'd9));
      corr_hi = c_q | (~n_q & (a_q > 8'h99));
      corr_d  = corr_q;
      daa_c_d = daa_c_q;
      if (state_q == ST_LO) begin
         corr_d  = {(corr_hi ? 4'h6 : 4'h0), (corr_lo ? 4'h6 : 4'h0)};
         daa_c_d = corr_hi;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         corr_q  <= '0;
         daa_c_q <= 1'b0;
      end else begin
         corr_q  <= corr_d;
         daa_c_q <= daa_c_d;
      end
   end
`else
   logic unused_daa_inputs;
   assign unused_daa_inputs = h_q ^ n_q;
`endif

   // ---------------- nibble core operand select ----------------
   always_comb begin
      nib_mode = NIB_ADD;
      nib_a    = (state_q == ST_HI) ? a_q[WORD_SIZE-1:NIBBLE] : a_q[NIBBLE-1:0];
      nib_b    = (state_q == ST_HI) ? b_q[WORD_SIZE-1:NIBBLE] : b_q[NIBBLE-1:0];
      nib_cin  = (state_q == ST_HI) ? nc_q
                                    : (((op_q == OP_ADC) || (op_q == OP_SBC)) ? c_q : 1'b0);
      case (op_q)
         OP_SUB, OP_SBC, OP_CP: nib_mode = NIB_SUB;
         OP_AND:                nib_mode = NIB_AND;
         OP_XOR:                nib_mode = NIB_XOR;
         OP_OR:                 nib_mode = NIB_OR;
`ifdef SM83_ALU_DAA_EN
         OP_DAA: begin
            nib_mode = n_q ? NIB_SUB : NIB_ADD;
            nib_b    = (state_q == ST_HI) ? corr_q[WORD_SIZE-1:NIBBLE] : corr_d[NIBBLE-1:0];
         end
`endif
         default:               nib_mode = NIB_ADD;
      endcase
   end

   sm83_alu_nibble u_nibble (
      .a_i  (nib_a),
      .b_i  (nib_b),
      .cin  (nib_cin),
      .mode (nib_mode),
      .y    (nib_y),
      .cout (nib_cout)
   );

   assign sh       = shift_op(op_q, a_q, c_q);
   assign is_shift = op_q inside {OP_RLC, OP_RRC, OP_RL, OP_RR, OP_SLA, OP_SRA, OP_SRL, OP_SWAP};

   // ---------------- datapath next-state ----------------
   always_comb begin
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      c_d      = c_q;
      h_d      = h_q;
      n_d      = n_q;
      lo_d     = lo_q;
      nc_d     = nc_q;
      result_d = result_q;
      zero_d   = zero_q;
      half_d   = half_q;
      carry_d  = carry_q;
      neg_d    = neg_q;
      shift_d  = shift_q;
      daac_d   = daac_q;
      valid_d  = 1'b0;
      res_full = {nib_y, lo_q};
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               op_d = op;
               a_d  = a;
               b_d  = b;
               c_d  = carry_in;
               h_d  = half_in;
               n_d  = neg_in;
            end
         end
         ST_LO: begin
            lo_d = is_shift ? sh[NIBBLE-1:0] : nib_y;
            nc_d = nib_cout;
         end
         ST_HI: begin
            // Unsupported codes fall through with result = a and every flag clear.
            valid_d  = 1'b1;
            result_d = a_q;
            zero_d   = 1'b0;
            half_d   = 1'b0;
            carry_d  = 1'b0;
            neg_d    = 1'b0;
            shift_d  = 1'b0;
            daac_d   = 1'b0;
            case (op_q)
               OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
                  result_d = res_full;
                  zero_d   = (res_full == '0);
                  half_d   = nc_q;
                  carry_d  = nib_cout;
                  neg_d    = (op_q == OP_SUB) || (op_q == OP_SBC);
               end
               OP_CP: begin
                  zero_d  = (res_full == '0);
                  half_d  = nc_q;
                  carry_d = nib_cout;
                  neg_d   = 1'b1;
               end
               OP_AND, OP_XOR, OP_OR: begin
                  result_d = res_full;
                  zero_d   = (res_full == '0);
                  half_d   = (op_q == OP_AND);
               end
               OP_RLC, OP_RRC, OP_RL, OP_RR, OP_SLA, OP_SRA, OP_SRL, OP_SWAP: begin
                  result_d = {sh[WORD_SIZE-1:NIBBLE], lo_q};
                  zero_d   = ({sh[WORD_SIZE-1:NIBBLE], lo_q} == '0);
                  carry_d  = sh[8];
                  shift_d  = sh[8];
               end
`ifdef SM83_ALU_DAA_EN
               OP_DAA: begin
                  result_d = res_full;
                  zero_d   = (res_full == '0);
                  carry_d  = daa_c_q;
                  daac_d   = daa_c_q;
                  neg_d    = n_q;
               end
`endif
               default: ;
            endcase
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         op_q     <= OP_ADD;
         a_q      <= '0;
         b_q      <= '0;
         c_q      <= 1'b0;
         h_q      <= 1'b0;
         n_q      <= 1'b0;
         lo_q     <= '0;
         nc_q     <= 1'b0;
         result_q <= '0;
         zero_q   <= 1'b0;
         half_q   <= 1'b0;
         carry_q  <= 1'b0;
         neg_q    <= 1'b0;
         shift_q  <= 1'b0;
         daac_q   <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         c_q      <= c_d;
         h_q      <= h_d;
         n_q      <= n_d;
         lo_q     <= lo_d;
         nc_q     <= nc_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         half_q   <= half_d;
         carry_q  <= carry_d;
         neg_q    <= neg_d;
         shift_q  <= shift_d;
         daac_q   <= daac_d;
         valid_q  <= valid_d;
      end
   end

   assign valid         = valid_q;
   assign result        = result_q;
   assign zero_out      = zero_q;
   assign half_out      = half_q;
   assign carry_out     = carry_q;
   assign neg_out       = neg_q;
   assign shift_out     = shift_q;
   assign daa_carry_out = daac_q;

endmodule

// File: tb/tb_sm83_alu_nibble_seq.sv
// Directed bench for sm83_alu_nibble_seq; DAA expectations follow SM83_ALU_DAA_EN.
// Flags are compared as {zero, half, carry, neg, shift_out, daa_carry}.
module tb_sm83_alu_nibble_seq;
   import sm83_alu_pkg::*;

   logic       clk, reset_n, start;
   alu_op_t    op;
   logic [7:0] a, b;
   logic       carry_in, half_in, neg_in;
   logic       busy, valid;
   logic [7:0] result;
   logic       zero_out, half_out, carry_out, neg_out, shift_out, daa_carry_out;
   alu_state_t state_dbg;
   logic [5:0] flags;

   int tests_run    = 0;
   int tests_failed = 0;
   logic [7:0] exp_q[$];

   typedef struct {
      alu_op_t    op;
      logic [7:0] a;
      logic [7:0] b;
      logic       c;
      logic       h;
      logic       n;
      logic [7:0] res;
      logic [5:0] fl;
      string      name;
   } vec_t;

   assign flags = {zero_out, half_out, carry_out, neg_out, shift_out, daa_carry_out};

   sm83_alu_nibble_seq #(.WORD_SIZE(8)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .start         (start),
      .op            (op),
      .a             (a),
      .b             (b),
      .carry_in      (carry_in),
      .half_in       (half_in),
      .neg_in        (neg_in),
      .busy          (busy),
      .valid         (valid),
      .result        (result),
      .zero_out      (zero_out),
      .half_out      (half_out),
      .carry_out     (carry_out),
      .neg_out       (neg_out),
      .shift_out     (shift_out),
      .daa_carry_out (daa_carry_out),
      .state_dbg     (state_dbg)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   // ---------------- driver ----------------
   task automatic drive(input alu_op_t o, input logic [7:0] av, input logic [7:0] bv,
                        input logic ci, input logic hi, input logic ni);
      op       = o;
      a        = av;
      b        = bv;
      carry_in = ci;
      half_in  = hi;
      neg_in   = ni;
      start    = 1'b1;
   endtask

   // Pulses start for one cycle, then waits (bounded) for valid; lat counts
   // falling edges after the start-sampling edge.
   task automatic run_op(input alu_op_t o, input logic [7:0] av, input logic [7:0] bv,
                         input logic ci, input logic hi, input logic ni, output int lat);
      @(negedge clk);
      drive(o, av, bv, ci, hi, ni);
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      while (valid !== 1'b1 && lat < 8) begin
         @(negedge clk);
         lat++;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset_n = 1'b0;
      start   = 1'b0;
      drive(OP_ADD, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      start   = 1'b0;
      repeat (2) @(negedge clk);
      tests_run++;
      if ({busy, valid} !== 2'b00) begin
         tests_failed++;
         $display("FAIL reset_busy_valid: got %b expected 00", {busy, valid});
      end
      tests_run++;
      if ({result, flags} !== 14'h0) begin
         tests_failed++;
         $display("FAIL reset_outputs: got result %h flags %b expected 00 000000", result, flags);
      end
      tests_run++;
      if (state_dbg !== ST_IDLE) begin
         tests_failed++;
         $display("FAIL reset_state: got %0d expected %0d", state_dbg, ST_IDLE);
      end
      reset_n = 1'b1;
   endtask

   task automatic run_table(input vec_t v[$]);
      int lat;
      foreach (v[i]) begin
         run_op(v[i].op, v[i].a, v[i].b, v[i].c, v[i].h, v[i].n, lat);
         tests_run++;
         if (lat !== 3) begin
            tests_failed++;
            $display("FAIL %s_latency: got %0d expected 3", v[i].name, lat);
         end
         tests_run++;
         if (result !== v[i].res) begin
            tests_failed++;
            $display("FAIL %s_result: got %h expected %h", v[i].name, result, v[i].res);
         end
         tests_run++;
         if (flags !== v[i].fl) begin
            tests_failed++;
            $display("FAIL %s_flags: got %b expected %b", v[i].name, flags, v[i].fl);
         end
      end
   endtask

   task automatic test_arith();
      vec_t v[$];
      v.push_back('{OP_ADD, 8'h3A, 8'hC6, 1'b0, 1'b0, 1'b0, 8'h00, 6'b111000, "add_3a_c6"});
      v.push_back('{OP_ADC, 8'h0F, 8'h00, 1'b1, 1'b0, 1'b0, 8'h10, 6'b010000, "adc_0f_00_c1"});
      v.push_back('{OP_SUB, 8'h10, 8'h01, 1'b0, 1'b0, 1'b0, 8'h0F, 6'b010100, "sub_10_01"});
      v.push_back('{OP_SBC, 8'h3B, 8'h4F, 1'b1, 1'b0, 1'b0, 8'hEB, 6'b011100, "sbc_3b_4f_c1"});
      v.push_back('{OP_CP,  8'h3E, 8'h3E, 1'b0, 1'b0, 1'b0, 8'h3E, 6'b100100, "cp_3e_3e"});
      run_table(v);
   endtask

   task automatic test_logic();
      vec_t v[$];
      v.push_back('{OP_AND, 8'h0F, 8'hF0, 1'b1, 1'b0, 1'b0, 8'h00, 6'b110000, "and_0f_f0"});
      v.push_back('{OP_XOR, 8'h5A, 8'hFF, 1'b1, 1'b0, 1'b0, 8'hA5, 6'b000000, "xor_5a_ff"});
      v.push_back('{OP_OR,  8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 6'b100000, "or_00_00"});
      run_table(v);
   endtask

   task automatic test_shift();
      vec_t v[$];
      v.push_back('{OP_RLC,  8'h85, 8'h00, 1'b0, 1'b0, 1'b0, 8'h0B, 6'b001010, "rlc_85"});
      v.push_back('{OP_RR,   8'h01, 8'h00, 1'b1, 1'b0, 1'b0, 8'h80, 6'b001010, "rr_01_c1"});
      v.push_back('{OP_SRA,  8'h81, 8'h00, 1'b0, 1'b0, 1'b0, 8'hC0, 6'b001010, "sra_81"});
      v.push_back('{OP_SLA,  8'h80, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 6'b101010, "sla_80"});
      v.push_back('{OP_SWAP, 8'hF0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h0F, 6'b000000, "swap_f0"});
      run_table(v);
   endtask

   task automatic test_daa();
      vec_t v[$];
`ifdef SM83_ALU_DAA_EN
      v.push_back('{OP_DAA, 8'h3C, 8'h00, 1'b0, 1'b0, 1'b0, 8'h42, 6'b000000, "daa_3c"});
      v.push_back('{OP_DAA, 8'h9A, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 6'b101001, "daa_9a"});
      v.push_back('{OP_DAA, 8'h0F, 8'h00, 1'b0, 1'b1, 1'b1, 8'h09, 6'b000100, "daa_sub_0f"});
`else
      v.push_back('{OP_DAA, 8'h3C, 8'h00, 1'b0, 1'b0, 1'b0, 8'h3C, 6'b000000, "daa_off_3c"});
      v.push_back('{OP_DAA, 8'h9A, 8'h00, 1'b1, 1'b1, 1'b1, 8'h9A, 6'b000000, "daa_off_9a"});
`endif
      v.push_back('{alu_op_t'(5'd20), 8'h00, 8'h55, 1'b1, 1'b1, 1'b1, 8'h00, 6'b000000, "unsupported_op"});
      run_table(v);
   endtask

   task automatic test_valid_pulse();
      int lat;
      run_op(OP_OR, 8'h30, 8'h03, 1'b0, 1'b0, 1'b0, lat);
      @(negedge clk);
      tests_run++;
      if (valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL valid_one_cycle: got %b expected 0", valid);
      end
      tests_run++;
      if (result !== 8'h33) begin
         tests_failed++;
         $display("FAIL result_hold: got %h expected 33", result);
      end
   endtask

   task automatic test_start_while_busy();
      int pulses = 0;
      @(negedge clk);
      drive(OP_ADD, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      drive(OP_SUB, 8'hFF, 8'h01, 1'b1, 1'b0, 1'b0);
      tests_run++;
      if (busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL busy_in_lo: got %b expected 1", busy);
      end
      @(negedge clk);
      drive(OP_XOR, 8'hAA, 8'h55, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      start = 1'b0;
      tests_run++;
      if ({valid, result, flags} !== {1'b1, 8'h03, 6'b000000}) begin
         tests_failed++;
         $display("FAIL busy_start_ignored: got valid %b result %h flags %b expected 1 03 000000",
                  valid, result, flags);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (valid === 1'b1) pulses++;
      end
      tests_run++;
      if (pulses !== 0) begin
         tests_failed++;
         $display("FAIL busy_no_extra_valid: got %0d pulses expected 0", pulses);
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      exp_q.push_back(8'h26);
      exp_q.push_back(8'h45);
      run_op(OP_XOR, 8'h12, 8'h34, 1'b0, 1'b0, 1'b0, lat);
      tests_run++;
      if (result !== exp_q[0] || lat !== 3) begin
         tests_failed++;
         $display("FAIL b2b_first: got %h lat %0d expected %h lat 3", result, lat, exp_q[0]);
      end
      void'(exp_q.pop_front());
      drive(OP_OR, 8'h40, 8'h05, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      start = 1'b0;
      tests_run++;
      if ({busy, valid} !== 2'b10) begin
         tests_failed++;
         $display("FAIL b2b_accepted: got busy,valid %b expected 10", {busy, valid});
      end
      lat = 1;
      while (valid !== 1'b1 && lat < 8) begin
         @(negedge clk);
         lat++;
      end
      tests_run++;
      if (result !== exp_q[0] || lat !== 3) begin
         tests_failed++;
         $display("FAIL b2b_second: got %h lat %0d expected %h lat 3", result, lat, exp_q[0]);
      end
      void'(exp_q.pop_front());
   endtask

   task automatic test_reset_mid_op();
      int pulses = 0;
      int lat;
      @(negedge clk);
      drive(OP_ADD, 8'h3A, 8'hC6, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      tests_run++;
      if (state_dbg !== ST_HI) begin
         tests_failed++;
         $display("FAIL mid_reach_hi: got state %0d expected %0d", state_dbg, ST_HI);
      end
      reset_n = 1'b0;
      #1;
      tests_run++;
      if ({busy, valid, result, flags} !== 16'h0) begin
         tests_failed++;
         $display("FAIL mid_reset_clear: got busy %b valid %b result %h flags %b expected 0 0 00 000000",
                  busy, valid, result, flags);
      end
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (valid === 1'b1) pulses++;
      end
      tests_run++;
      if (pulses !== 0) begin
         tests_failed++;
         $display("FAIL mid_no_valid: got %0d pulses expected 0", pulses);
      end
      run_op(OP_AND, 8'hFF, 8'h81, 1'b0, 1'b0, 1'b0, lat);
      tests_run++;
      if ({result, flags} !== {8'h81, 6'b010000} || lat !== 3) begin
         tests_failed++;
         $display("FAIL after_reset_op: got %h %b lat %0d expected 81 010000 lat 3",
                  result, flags, lat);
      end
   endtask

   initial begin
      test_reset();
      test_arith();
      test_logic();
      test_shift();
      test_daa();
      test_valid_pulse();
      test_start_while_busy();
      test_back_to_back();
      test_reset_mid_op();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
